// File: rtl/riscv_pipeline_controller_pkg.sv
// Shared encodings for the RV32I pipeline controller: opcodes, branch func3 values,
// controller FSM states and the ID-stage load-use hazard check.
package riscv_pipeline_controller_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } ctrl_state_e;

    // x0 is never written, so a load targeting it cannot create a hazard.
    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       id_uses_rs1,
        input logic       id_uses_rs2
    );
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/riscv_pipeline_controller_branch_resolve.sv
// Combinational redirect decode for the EX stage: JAL, JALR and taken conditional branches.
module riscv_branch_resolve
    import riscv_pipeline_controller_pkg::*;
(
    input  logic [6:0] ex_opcode,
    input  logic [2:0] ex_func3,
    input  logic       ex_zero,
    input  logic       ex_less_than,
    input  logic       ex_less_than_u,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (ex_opcode)
            OP_JAL, OP_JALR: taken = 1'b1;
            OP_BRANCH: begin
                unique case (ex_func3)
                    F3_BEQ:  taken = ex_zero;
                    F3_BNE:  taken = !ex_zero;
                    F3_BLT:  taken = ex_less_than;
                    F3_BGE:  taken = !ex_less_than;
                    F3_BLTU: taken = ex_less_than_u;
                    F3_BGEU: taken = !ex_less_than_u;
                    default: taken = 1'b0;
                endcase
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_pipeline_controller.sv
// Stall/flush/redirect sequencer for the 5-stage RV32I pipeline, with a memory-wait
// timeout FSM and saturating stall/flush performance counters.
module riscv_pipeline_controller
    import riscv_pipeline_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TMO_W          = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic [6:0]       ex_opcode,
    input  logic [2:0]       ex_func3,
    input  logic             ex_zero,
    input  logic             ex_less_than,
    input  logic             ex_less_than_u,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_hold,
    output logic             pc_src,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    ctrl_state_e      state_q, state_d;
    logic [TMO_W-1:0] wait_q, wait_d;
    logic [TMO_W-1:0] wait_inc;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic redirect;
    logic load_use;
    logic memwait;

    riscv_branch_resolve u_branch_resolve (
        .ex_opcode      (ex_opcode),
        .ex_func3       (ex_func3),
        .ex_zero        (ex_zero),
        .ex_less_than   (ex_less_than),
        .ex_less_than_u (ex_less_than_u),
        .taken          (redirect)
    );

    assign load_use = load_use_hazard(ex_mem_read, ex_rd, id_rs1, id_rs2,
                                      id_uses_rs1, id_uses_rs2);
    assign memwait  = mem_req && !mem_ready;
    assign wait_inc = wait_q + TMO_W'(1);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_RUN: begin
                if (memwait) begin
                    wait_d  = TMO_W'(1);
                    state_d = (TMO_W'(1) >= TMO_LIMIT) ? ST_ERROR : ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (memwait) begin
                    wait_d  = wait_inc;
                    state_d = (wait_inc >= TMO_LIMIT) ? ST_ERROR : ST_MEM_WAIT;
                end else begin
                    wait_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RUN;
        endcase
    end

    // Reset override is combinational so the pipeline is held flushed while rst_n is low.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_hold   = 1'b0;
        pc_src      = 1'b0;
        mem_timeout = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (state_q == ST_ERROR) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
            mem_timeout = 1'b1;
        end else if (memwait) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (redirect) begin
            pc_src      = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q != ST_ERROR) && !pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (pc_src && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_riscv_pipeline_controller.sv
// Directed self-checking bench for riscv_pipeline_controller (TIMEOUT_CYCLES=4, CNT_W=4).
module tb_riscv_pipeline_controller;

    localparam int unsigned CW = 4;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, pc_src, mem_timeout}
    localparam logic [6:0] O_RUN   = 7'b1100000;
    localparam logic [6:0] O_STALL = 7'b0001000;
    localparam logic [6:0] O_REDIR = 7'b1111010;
    localparam logic [6:0] O_HOLD  = 7'b0000100;
    localparam logic [6:0] O_ERR   = 7'b0000101;
    localparam logic [6:0] O_RST   = 7'b0011000;

    typedef struct {
        string         tag;
        logic [6:0]    outs;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic [6:0]    ex_opcode;
    logic [2:0]    ex_func3;
    logic          ex_zero, ex_less_than, ex_less_than_u;
    logic          mem_req, mem_ready;
    logic          pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic          pipe_hold, pc_src, mem_timeout;
    logic [CW-1:0] stall_count, flush_count;

    exp_t          sb[$];
    int            n_assert = 0;
    int            n_fail   = 0;
    logic [CW-1:0] m_stall  = '0;
    logic [CW-1:0] m_flush  = '0;

    riscv_pipeline_controller #(
        .TIMEOUT_CYCLES (4),
        .TMO_W          (16),
        .CNT_W          (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_opcode      (ex_opcode),
        .ex_func3       (ex_func3),
        .ex_zero        (ex_zero),
        .ex_less_than   (ex_less_than),
        .ex_less_than_u (ex_less_than_u),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .pipe_hold      (pipe_hold),
        .pc_src         (pc_src),
        .mem_timeout    (mem_timeout),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_opcode = 7'b0110011; ex_func3 = 3'b000;
        ex_zero = 1'b0; ex_less_than = 1'b0; ex_less_than_u = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic branch(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
        ex_opcode = 7'b1100011; ex_func3 = f3;
        ex_zero = z; ex_less_than = lt; ex_less_than_u = ltu;
    endtask

    task automatic load_use_rs2(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    endtask

    // Inputs for a cycle are applied at the falling edge, just before this is called.
    task automatic check(input string tag, input logic [6:0] exp_o);
        exp_t e;
        logic [6:0] obs;
        if (!rst_n) begin
            m_stall = '0;
            m_flush = '0;
        end
        sb.push_back('{tag, exp_o, m_stall, m_flush});
        #2;
        e   = sb.pop_front();
        obs = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, pc_src, mem_timeout};
        n_assert++;
        assert (obs === e.outs) else begin
            n_fail++;
            $error("FAIL %s outs: observed %b expected %b", e.tag, obs, e.outs);
        end
        n_assert++;
        assert (stall_count === e.stall) else begin
            n_fail++;
            $error("FAIL %s stall_count: observed %0d expected %0d", e.tag, stall_count, e.stall);
        end
        n_assert++;
        assert (flush_count === e.flush) else begin
            n_fail++;
            $error("FAIL %s flush_count: observed %0d expected %0d", e.tag, flush_count, e.flush);
        end
        if (rst_n && !exp_o[6] && !exp_o[0] && (m_stall != '1)) m_stall = m_stall + 1'b1;
        if (exp_o[1] && (m_flush != '1)) m_flush = m_flush + 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk); check("reset", O_RST);
        @(negedge clk); rst_n = 1'b1; check("idle", O_RUN);

        @(negedge clk); branch(3'b110, 1'b0, 1'b0, 1'b1); check("bltu_taken", O_REDIR);
        @(negedge clk); branch(3'b111, 1'b0, 1'b0, 1'b1); check("bgeu_not", O_RUN);
        @(negedge clk); branch(3'b000, 1'b1, 1'b0, 1'b0); check("beq_taken", O_REDIR);
        @(negedge clk); branch(3'b001, 1'b1, 1'b0, 1'b0); check("bne_not", O_RUN);
        @(negedge clk); branch(3'b010, 1'b1, 1'b1, 1'b1); check("f3_010", O_RUN);
        @(negedge clk); branch(3'b011, 1'b0, 1'b0, 1'b0); check("f3_011", O_RUN);
        @(negedge clk); branch(3'b100, 1'b0, 1'b1, 1'b0); check("blt_taken", O_REDIR);
        @(negedge clk); branch(3'b101, 1'b0, 1'b1, 1'b0); check("bge_not", O_RUN);
        @(negedge clk); branch(3'b101, 1'b0, 1'b0, 1'b1); check("bge_taken", O_REDIR);
        @(negedge clk); idle(); ex_opcode = 7'b1100111; check("jalr", O_REDIR);

        @(negedge clk); idle(); load_use_rs2(5'd5); check("load_use", O_STALL);
        @(negedge clk); idle(); check("after_bubble", O_RUN);
        @(negedge clk); load_use_rs2(5'd0); check("load_x0", O_RUN);
        @(negedge clk); idle(); id_rs1 = 5'd5; load_use_rs2(5'd5); id_uses_rs2 = 1'b0;
        check("rs1_unused", O_RUN);

        @(negedge clk); idle(); load_use_rs2(5'd5); ex_opcode = 7'b1101111;
        check("jal_over_lu", O_REDIR);
        @(negedge clk); mem_req = 1'b1; mem_ready = 1'b0; check("memwait_1", O_HOLD);
        @(negedge clk); check("memwait_2", O_HOLD);
        @(negedge clk); mem_ready = 1'b1; check("release_jal", O_REDIR);

        @(negedge clk); idle(); mem_req = 1'b1; mem_ready = 1'b0; check("tmo_w1", O_HOLD);
        @(negedge clk); check("tmo_w2", O_HOLD);
        @(negedge clk); check("tmo_w3", O_HOLD);
        @(negedge clk); check("tmo_w4", O_HOLD);
        @(negedge clk); check("tmo_error", O_ERR);
        @(negedge clk); mem_ready = 1'b1; check("err_sticky", O_ERR);
        @(negedge clk); mem_req = 1'b0; ex_opcode = 7'b1101111; check("err_jal", O_ERR);
        @(negedge clk); rst_n = 1'b0; check("rst_in_err", O_RST);
        @(negedge clk); rst_n = 1'b1; idle(); check("err_cleared", O_RUN);

        @(negedge clk); load_use_rs2(5'd5); check("pre_lu", O_STALL);
        @(negedge clk); idle(); ex_opcode = 7'b1101111; check("pre_jal", O_REDIR);
        @(negedge clk); idle(); mem_req = 1'b1; mem_ready = 1'b0; check("mw_1", O_HOLD);
        @(negedge clk); check("mw_2", O_HOLD);
        #1 rst_n = 1'b0; check("rst_mid_wait", O_RST);
        @(negedge clk); rst_n = 1'b1; idle(); check("post_rst", O_RUN);
        @(negedge clk); mem_req = 1'b1; mem_ready = 1'b1; check("mem_ready_now", O_RUN);

        @(negedge clk); idle(); load_use_rs2(5'd5);
        for (int i = 0; i < 18; i++) begin
            check("sat_stall", O_STALL);
            @(negedge clk);
        end
        idle(); check("sat_hold", O_RUN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
